// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: bundles the per-digit pattern inputs and the scanned
// pin outputs of seg_scan_driver.
//   master : pattern source (clock core / testbench); drives the patterns
//            and observes the pins
//   slave  : seg_scan_driver
// Signals: segments_in, digit_enable, brightness (master->slave);
//          led_segments, led_enable_mask, frame_start, current_digit
//          (slave->master).
// Optional: SEG_SCAN_LAMP_TEST_EN adds lamp_test (master->slave).
interface seg_scan_driver_if #(
  parameter int DIGITS      = 6,
  parameter int SEG_WIDTH   = 8,
  parameter int BRIGHT_BITS = 4
);
  localparam int DW = $clog2(DIGITS);

  logic [DIGITS*SEG_WIDTH-1:0] segments_in;
  logic [DIGITS-1:0]           digit_enable;
  logic [BRIGHT_BITS-1:0]      brightness;
`ifdef SEG_SCAN_LAMP_TEST_EN
  logic                        lamp_test;
`endif
  logic [SEG_WIDTH-1:0]        led_segments;
  logic [DIGITS-1:0]           led_enable_mask;
  logic                        frame_start;
  logic [DW-1:0]               current_digit;

  modport master (
`ifdef SEG_SCAN_LAMP_TEST_EN
    output lamp_test,
`endif
    output segments_in, digit_enable, brightness,
    input  led_segments, led_enable_mask, frame_start, current_digit
  );

  modport slave (
`ifdef SEG_SCAN_LAMP_TEST_EN
    input  lamp_test,
`endif
    input  segments_in, digit_enable, brightness,
    output led_segments, led_enable_mask, frame_start, current_digit
  );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed N-digit 7-segment scanner.
// Each digit gets a slot of SLOT_CYCLES clocks: BLANK_CYCLES all-off cycles
// (ghost suppression) followed by an ON window where the digit enable is
// PWM-gated by a BRIGHT_BITS brightness code. Inputs are captured once per
// frame into a shadow so a frame never tears.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : seg_scan_driver_if.slave (patterns in, pins out)
// Optional feature macro: SEG_SCAN_LAMP_TEST_EN (adds bus.lamp_test; when
// latched high every ON cycle lights all segments of the scanned digit).
module seg_scan_driver #(
  parameter int CLK_RATE_HZ    = 100_000_000,
  parameter int DIGITS         = 6,
  parameter int SEG_WIDTH      = 8,
  parameter int REFRESH_HZ     = 200,
  parameter int BLANK_CYCLES   = 64,
  parameter int BRIGHT_BITS    = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit EN_ACTIVE_LOW  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_driver_if.slave  bus
);
  localparam int SLOT_CYCLES = CLK_RATE_HZ / (REFRESH_HZ * DIGITS);
  localparam int SW = $clog2(SLOT_CYCLES);
  localparam int DW = $clog2(DIGITS);
  localparam logic [SW-1:0]          BLANK_S  = SW'(BLANK_CYCLES);
  localparam logic [SW-1:0]          SLOT_END = SW'(SLOT_CYCLES - 1);
  localparam logic [DW-1:0]          DIG_END  = DW'(DIGITS - 1);
  localparam logic [BRIGHT_BITS-1:0] BR_FULL  = '1;
  localparam logic [SEG_WIDTH-1:0]   SEG_OFF  = {SEG_WIDTH{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0]      EN_OFF   = {DIGITS{EN_ACTIVE_LOW}};

  generate
    if (DIGITS < 2) begin : g_bad_digits
      $error("seg_scan_driver: DIGITS must be >= 2");
    end
    if (SLOT_CYCLES <= BLANK_CYCLES + (1 << BRIGHT_BITS)) begin : g_bad_slot
      $error("seg_scan_driver: slot too short for blank + one PWM period");
    end
  endgenerate

  typedef struct packed {
    logic [DIGITS-1:0][SEG_WIDTH-1:0] seg;
    logic [DIGITS-1:0]                en;
    logic [BRIGHT_BITS-1:0]           br;
`ifdef SEG_SCAN_LAMP_TEST_EN
    logic                             lamp;
`endif
  } frame_t;

  logic [SW-1:0]          s;
  logic [DW-1:0]          d;
  frame_t                 shadow, live, cur;
  logic                   frame_begin;
  logic                   in_on, pwm_on, sel_on;
  logic [BRIGHT_BITS-1:0] p;
  logic [SEG_WIDTH-1:0]   seg_lit, seg_nxt;
  logic [DIGITS-1:0]      mask_act;
  logic [SEG_WIDTH-1:0]   seg_q;
  logic [DIGITS-1:0]      mask_q;
  logic                   fs_q;
  logic [DW-1:0]          cd_q;

  assign live.seg = bus.segments_in;
  assign live.en  = bus.digit_enable;
  assign live.br  = bus.brightness;
`ifdef SEG_SCAN_LAMP_TEST_EN
  assign live.lamp = bus.lamp_test;
`endif

  // Frame cycle 0 is emitted on the same edge that captures the shadow, so
  // that cycle has to look at the live inputs rather than the stale shadow.
  assign frame_begin = (s == '0) && (d == '0);
  assign cur         = frame_begin ? live : shadow;

  assign in_on  = (s >= BLANK_S);
  assign p      = BRIGHT_BITS'(s - BLANK_S);
  assign pwm_on = (p < cur.br) || (cur.br == BR_FULL);

  always_comb begin
    seg_lit = cur.seg[d];
    sel_on  = cur.en[d] && pwm_on;
`ifdef SEG_SCAN_LAMP_TEST_EN
    if (cur.lamp) begin
      seg_lit = '1;
      sel_on  = 1'b1;
    end
`endif
  end

  // Segments stay driven through the ON window even when the digit is
  // gated off; only the enable carries brightness/disable.
  assign seg_nxt = in_on ? seg_lit : '0;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lane
      assign mask_act[gi] = in_on && sel_on && (d == DW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s      <= '0;
      d      <= '0;
      shadow <= '0;
      seg_q  <= SEG_OFF;
      mask_q <= EN_OFF;
      fs_q   <= 1'b0;
      cd_q   <= '0;
    end else begin
      if (frame_begin) shadow <= live;
      seg_q  <= seg_nxt ^ SEG_OFF;
      mask_q <= mask_act ^ EN_OFF;
      fs_q   <= frame_begin;
      cd_q   <= d;
      if (s == SLOT_END) begin
        s <= '0;
        d <= (d == DIG_END) ? '0 : d + DW'(1);
      end else begin
        s <= s + SW'(1);
      end
    end
  end

  assign bus.led_segments    = seg_q;
  assign bus.led_enable_mask = mask_q;
  assign bus.frame_start     = fs_q;
  assign bus.current_digit   = cd_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;
  localparam int FRAME = 120;
  localparam int SLOT  = 30;
  localparam int BLANK = 4;

  typedef struct packed {
    logic [7:0] seg_h;
    logic [3:0] mask_h;
    logic [7:0] seg_l;
    logic [3:0] mask_l;
    logic       fs;
    logic [1:0] cd;
  } out_t;

  localparam out_t RESET_OBS = '{seg_h: 8'h00, mask_h: 4'h0, seg_l: 8'hFF,
                                 mask_l: 4'hF, fs: 1'b0, cd: 2'd0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] seg_in = '0;
  logic [3:0]  en_in = '0;
  logic [1:0]  br_in = '0;

  int errors = 0;
  int checks = 0;

  seg_scan_driver_if #(.DIGITS(4), .SEG_WIDTH(8), .BRIGHT_BITS(2)) bus_h ();
  seg_scan_driver_if #(.DIGITS(4), .SEG_WIDTH(8), .BRIGHT_BITS(2)) bus_l ();

  assign bus_h.segments_in  = seg_in;
  assign bus_h.digit_enable = en_in;
  assign bus_h.brightness   = br_in;
  assign bus_l.segments_in  = seg_in;
  assign bus_l.digit_enable = en_in;
  assign bus_l.brightness   = br_in;
`ifdef SEG_SCAN_LAMP_TEST_EN
  assign bus_h.lamp_test = 1'b0;
  assign bus_l.lamp_test = 1'b0;
`endif

  seg_scan_driver #(
    .CLK_RATE_HZ(1200), .DIGITS(4), .SEG_WIDTH(8), .REFRESH_HZ(10),
    .BLANK_CYCLES(4), .BRIGHT_BITS(2), .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b0)
  ) u_dut_h (.clk(clk), .rst_n(rst_n), .bus(bus_h));

  seg_scan_driver #(
    .CLK_RATE_HZ(1200), .DIGITS(4), .SEG_WIDTH(8), .REFRESH_HZ(10),
    .BLANK_CYCLES(4), .BRIGHT_BITS(2), .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)
  ) u_dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));

  always #5 clk = ~clk;

  // Reference model: on every active edge out of reset, predict the pins for
  // that output cycle from the frame snapshot and push onto the scoreboard.
  out_t        sb[$];
  int          n = 0;
  int          m_fc, m_slot, m_s, m_q;
  logic [31:0] snap_seg;
  logic [3:0]  snap_en;
  logic [1:0]  snap_br;
  logic [7:0]  m_sg;
  logic [3:0]  m_mk;
  out_t        m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      sb.delete();
    end else begin
      m_fc = n % FRAME;
      if (m_fc == 0) begin
        snap_seg = seg_in;
        snap_en  = en_in;
        snap_br  = br_in;
      end
      m_slot = m_fc / SLOT;
      m_s    = m_fc % SLOT;
      if (m_s < BLANK) begin
        m_sg = 8'h00;
        m_mk = 4'h0;
      end else begin
        m_sg = snap_seg[m_slot*8 +: 8];
        m_q  = (m_s - BLANK) % 4;
        m_mk = (snap_en[m_slot] && (snap_br == 2'd3 || m_q < int'(snap_br)))
               ? 4'(1 << m_slot) : 4'h0;
      end
      m_e = '{seg_h: m_sg, mask_h: m_mk, seg_l: ~m_sg, mask_l: ~m_mk,
              fs: (m_fc == 0), cd: 2'(m_slot)};
      sb.push_back(m_e);
      n++;
    end
  end

  function automatic out_t observe();
    return '{seg_h: bus_h.led_segments, mask_h: bus_h.led_enable_mask,
             seg_l: bus_l.led_segments, mask_l: bus_l.led_enable_mask,
             fs: bus_h.frame_start, cd: bus_h.current_digit};
  endfunction

  // Advance one cycle, sample on the falling edge and pop the prediction.
  task automatic get_cycle(output out_t e, output out_t o, output bit ok);
    @(negedge clk);
    o  = observe();
    ok = (sb.size() > 0);
    e  = '0;
    if (ok) e = sb.pop_front();
  endtask

  task automatic test_reset();
    out_t e, o;
    bit   ok;
    int   fs_cnt = 0;
    rst_n  = 1'b0;
    seg_in = {8'h3F, 8'h06, 8'h5B, 8'h4F};
    en_in  = 4'hF;
    br_in  = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = observe();
      checks++;
      if (o !== RESET_OBS) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, o, RESET_OBS);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2*FRAME; i++) begin
      get_cycle(e, o, ok);
      checks++;
      if (!ok || o !== e) begin
        errors++;
        $display("FAIL first_frame cyc=%0d got=%h exp=%h sb_ok=%0d", i, o, e, ok);
      end
      if (o.fs) fs_cnt++;
      if (i == 0) begin
        checks++;
        if (o.fs !== 1'b1 || o.cd !== 2'd0) begin
          errors++;
          $display("FAIL first_cycle fs=%b cd=%0d exp fs=1 cd=0", o.fs, o.cd);
        end
      end
      if (i == 95) begin
        checks++;
        if (o.cd !== 2'd3) begin
          errors++;
          $display("FAIL digit_step cd=%0d exp=3", o.cd);
        end
      end
    end
    checks++;
    if (fs_cnt != 2) begin
      errors++;
      $display("FAIL frame_start_count got=%0d exp=2", fs_cnt);
    end
  endtask

  task automatic test_full_bright();
    out_t e, o;
    bit   ok;
    int   slot0_hits = 0, lit = 0;
    checks++;
    if (n % FRAME != 0) begin
      errors++;
      $display("FAIL align_full got=%0d exp=0", n % FRAME);
    end
    br_in = 2'd3;
    for (int i = 0; i < FRAME; i++) begin
      get_cycle(e, o, ok);
      checks++;
      if (!ok || o !== e) begin
        errors++;
        $display("FAIL full_bright cyc=%0d got=%h exp=%h sb_ok=%0d", i, o, e, ok);
      end
      if (i >= BLANK && i < SLOT && o.mask_h === 4'b0001 && o.seg_h === 8'h4F)
        slot0_hits++;
      if (o.mask_h !== 4'h0) lit++;
    end
    checks++;
    if (slot0_hits != 26) begin
      errors++;
      $display("FAIL slot0_lit got=%0d exp=26", slot0_hits);
    end
    checks++;
    if (lit != 104) begin
      errors++;
      $display("FAIL frame_lit got=%0d exp=104", lit);
    end
  endtask

  task automatic test_pwm();
    out_t e, o;
    bit   ok;
    int   act[4] = '{0, 0, 0, 0};
    br_in = 2'd1;
    for (int i = 0; i < FRAME; i++) begin
      get_cycle(e, o, ok);
      checks++;
      if (!ok || o !== e) begin
        errors++;
        $display("FAIL pwm cyc=%0d got=%h exp=%h sb_ok=%0d", i, o, e, ok);
      end
      if (o.mask_h !== 4'h0) act[i/SLOT]++;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act[k] != 7) begin
        errors++;
        $display("FAIL pwm_duty slot=%0d got=%0d exp=7", k, act[k]);
      end
    end
  endtask

  task automatic test_tear_free();
    out_t e, o;
    bit   ok;
    int   old_hits = 0, new_hits = 0;
    br_in = 2'd3;
    for (int i = 0; i < 2*FRAME; i++) begin
      if (i == 45) seg_in[23:16] = 8'hFF;
      get_cycle(e, o, ok);
      checks++;
      if (!ok || o !== e) begin
        errors++;
        $display("FAIL tear_free cyc=%0d got=%h exp=%h sb_ok=%0d", i, o, e, ok);
      end
      if (i >= 2*SLOT+BLANK && i < 3*SLOT && o.seg_h === 8'h06) old_hits++;
      if (i >= FRAME+2*SLOT+BLANK && i < FRAME+3*SLOT && o.seg_h === 8'hFF) new_hits++;
    end
    checks++;
    if (old_hits != 26) begin
      errors++;
      $display("FAIL tear_old got=%0d exp=26", old_hits);
    end
    checks++;
    if (new_hits != 26) begin
      errors++;
      $display("FAIL tear_new got=%0d exp=26", new_hits);
    end
  endtask

  task automatic test_disabled_polarity();
    out_t e, o;
    bit   ok;
    int   s2_dark = 0, s0_sel = 0, idle_seg = 0;
    en_in = 4'b1011;
    for (int i = 0; i < FRAME; i++) begin
      get_cycle(e, o, ok);
      checks++;
      if (!ok || o !== e) begin
        errors++;
        $display("FAIL disabled cyc=%0d got=%h exp=%h sb_ok=%0d", i, o, e, ok);
      end
      if (i >= 2*SLOT && i < 3*SLOT && o.mask_l === 4'hF) s2_dark++;
      if (i >= BLANK && i < SLOT && o.mask_l === 4'b1110) s0_sel++;
      if (i % SLOT < BLANK && o.seg_l === 8'hFF) idle_seg++;
    end
    checks++;
    if (s2_dark != 30) begin
      errors++;
      $display("FAIL slot2_dark got=%0d exp=30", s2_dark);
    end
    checks++;
    if (s0_sel != 26) begin
      errors++;
      $display("FAIL low_sel got=%0d exp=26", s0_sel);
    end
    checks++;
    if (idle_seg != 16) begin
      errors++;
      $display("FAIL idle_seg got=%0d exp=16", idle_seg);
    end
  endtask

  task automatic test_mid_reset();
    out_t e, o;
    bit   ok;
    en_in = 4'hF;
    for (int i = 0; i < 70; i++) begin
      get_cycle(e, o, ok);
      checks++;
      if (!ok || o !== e) begin
        errors++;
        $display("FAIL pre_reset cyc=%0d got=%h exp=%h sb_ok=%0d", i, o, e, ok);
      end
    end
    #2 rst_n = 1'b0;
    #1 o = observe();
    checks++;
    if (o !== RESET_OBS) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", o, RESET_OBS);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 130; i++) begin
      get_cycle(e, o, ok);
      checks++;
      if (!ok || o !== e) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got=%h exp=%h sb_ok=%0d", i, o, e, ok);
      end
      if (i == 0) begin
        checks++;
        if (o.fs !== 1'b1 || o.cd !== 2'd0) begin
          errors++;
          $display("FAIL restart fs=%b cd=%0d exp fs=1 cd=0", o.fs, o.cd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_bright();
    test_pwm();
    test_tear_free();
    test_disabled_polarity();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised multiplexed 7-segment display driver.
- Sits between the clock core's per-digit segment patterns and the board IO pins.
- Generalises the fixed 6-digit/8-segment pin mapping to N digits.
- Adds time-multiplexed scanning, inter-digit ghost blanking, PWM brightness, per-digit enable, selectable pin polarity, and tear-free frame capture.

Parameters:
- CLK_RATE_HZ, 100_000_000, input clock frequency.
- DIGITS, 6, number of digit positions (>=2).
- SEG_WIDTH, 8, segment lines per digit (7 segments + dp).
- REFRESH_HZ, 200, full-frame scan rate. SLOT_CYCLES = CLK_RATE_HZ/(REFRESH_HZ*DIGITS), integer division.
- BLANK_CYCLES, 64, all-off cycles at the start of each digit slot.
- BRIGHT_BITS, 4, brightness code width. Requires SLOT_CYCLES > BLANK_CYCLES + 2**BRIGHT_BITS (elaboration-time check).
- SEG_ACTIVE_LOW, 0, 1 = segment outputs driven low to light.
- EN_ACTIVE_LOW, 0, 1 = digit enable outputs driven low to select.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- segments_in  in  DIGITS*SEG_WIDTH  active-high patterns. Digit i is at bits [i*SEG_WIDTH +: SEG_WIDTH]; digit 0 is leftmost.
- digit_enable  in  DIGITS  1 = digit may light.
- brightness  in  BRIGHT_BITS  0 = dark, all-ones = full on.
- led_segments  out  SEG_WIDTH  registered segment pins, polarity per SEG_ACTIVE_LOW.
- led_enable_mask  out  DIGITS  registered digit selects, polarity per EN_ACTIVE_LOW, at most one active.
- frame_start  out  1  one-cycle pulse on the first output cycle of every frame.
- current_digit  out  $clog2(DIGITS)  index of the slot being presented.

Behaviour:
- Reset (async assert, sync release):
  - led_segments and led_enable_mask at inactive level.
  - frame_start=0, current_digit=0.
  - All counters and shadow registers cleared.
- Counters: slot cycle s in 0..SLOT_CYCLES-1 and digit d in 0..DIGITS-1.
  - s wraps to 0 and d increments.
  - d wraps from DIGITS-1 to 0; this wrap starts a new frame.
- Frame capture: on the clock edge that begins frame output cycle 0, segments_in, digit_enable and brightness are latched into shadow registers. Mid-frame input changes never affect the current frame.
- First frame: the first rising edge with rst_n high begins frame cycle 0. frame_start=1 on that output cycle.
- Per-slot states, with all outputs registered and driven from the current s and d:
  - BLANK (s < BLANK_CYCLES): all segments and all enables inactive.
  - ON (s >= BLANK_CYCLES): led_segments = shadow pattern of digit d. Let p = (s-BLANK_CYCLES) mod 2**BRIGHT_BITS. Enable bit d is active iff shadow_enable[d] && (p < shadow_brightness || shadow_brightness == all-ones). Segments are driven even when enable is inactive.
- current_digit = d for the whole slot, including BLANK.
- Boundaries:
  - brightness=0 → enables never active.
  - digit disabled → its slot is dark, and timing is unchanged (slots are never skipped).
  - Reset asserted mid-slot → outputs go inactive immediately; a fresh frame starts at digit 0 after release.

Optional Feature:
- Macro SEG_SCAN_LAMP_TEST_EN.
- Defined:
  - Adds input port lamp_test (1 bit), sampled with the frame shadow.
  - When the latched value is 1, every ON cycle drives all segments lit and enables digit d, ignoring digit_enable and brightness.
  - BLANK is still honoured.
- Undefined: the port is absent; behaviour is exactly as above.

Test Plan:
- Bench parameters: CLK_RATE_HZ=1200, REFRESH_HZ=10, DIGITS=4, SEG_WIDTH=8, BLANK_CYCLES=4, BRIGHT_BITS=2, giving SLOT_CYCLES=30.
- Reset/first frame: hold rst_n=0, then release → segments 8'h00, mask 4'h0 during reset. frame_start high on the first cycle after release, then every 120 cycles. current_digit steps 0,1,2,3 every 30 cycles.
- Full brightness: segments_in={8'h3F,8'h06,8'h5B,8'h4F}, enable 4'hF, brightness 3 → per slot, 4 dark cycles then 26 cycles lit. During slot 0 of that frame, mask=4'b0001 and segments=8'h4F.
- PWM: brightness 1 → in each ON window, enable pattern repeats 1,0,0,0. 7 of 26 ON cycles are active per slot.
- Tear-free: change segments_in digit 2 to 8'hFF at frame cycle 45 → the current frame still shows the old value; the next frame shows 8'hFF in slot 2.
- Disabled digit and polarity: digit_enable=4'b1011 with SEG_ACTIVE_LOW=1 and EN_ACTIVE_LOW=1 → slot 2 mask stays 4'hF. In other slots the active bit is 0, and idle segments read 8'hFF.
- Mid-operation reset: assert rst_n=0 at frame cycle 70 → outputs go inactive in the same cycle. After release, frame_start pulses and current_digit=0.
